// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - segment encoding, scan FSM states and hex digit patterns
package seven_seg_pkg;

  // bit 0 = segment a .. bit 6 = segment g, active-high
  typedef logic [6:0] seven_seg_t;

  typedef enum logic {
    SCAN_BLANK = 1'b0,
    SCAN_SHOW  = 1'b1
  } scan_state_t;

  localparam seven_seg_t SEG_0 = 7'h3F;
  localparam seven_seg_t SEG_1 = 7'h06;
  localparam seven_seg_t SEG_2 = 7'h5B;
  localparam seven_seg_t SEG_3 = 7'h4F;
  localparam seven_seg_t SEG_4 = 7'h66;
  localparam seven_seg_t SEG_5 = 7'h6D;
  localparam seven_seg_t SEG_6 = 7'h7D;
  localparam seven_seg_t SEG_7 = 7'h07;
  localparam seven_seg_t SEG_8 = 7'h7F;
  localparam seven_seg_t SEG_9 = 7'h6F;
  localparam seven_seg_t SEG_A = 7'h77;
  localparam seven_seg_t SEG_B = 7'h7C;
  localparam seven_seg_t SEG_C = 7'h39;
  localparam seven_seg_t SEG_D = 7'h5E;
  localparam seven_seg_t SEG_E = 7'h79;
  localparam seven_seg_t SEG_F = 7'h71;

  function automatic seven_seg_t hex_to_seg(input logic [3:0] hex);
    case (hex)
      4'h0:    hex_to_seg = SEG_0;
      4'h1:    hex_to_seg = SEG_1;
      4'h2:    hex_to_seg = SEG_2;
      4'h3:    hex_to_seg = SEG_3;
      4'h4:    hex_to_seg = SEG_4;
      4'h5:    hex_to_seg = SEG_5;
      4'h6:    hex_to_seg = SEG_6;
      4'h7:    hex_to_seg = SEG_7;
      4'h8:    hex_to_seg = SEG_8;
      4'h9:    hex_to_seg = SEG_9;
      4'hA:    hex_to_seg = SEG_A;
      4'hB:    hex_to_seg = SEG_B;
      4'hC:    hex_to_seg = SEG_C;
      4'hD:    hex_to_seg = SEG_D;
      4'hE:    hex_to_seg = SEG_E;
      default: hex_to_seg = SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/seven_seg.sv
// rtl/seven_seg.sv - combinational hex digit to seven-segment decoder
module seven_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(hex);

endmodule

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - time-multiplexed digit scan with dead-time blanking,
// leading-zero suppression and frame-aligned double buffering
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam scan_state_t   START_STATE = (BLANK_CYCLES == 0) ? SCAN_SHOW : SCAN_BLANK;

  logic [CW-1:0]           cnt, cnt_d;
  logic [IW-1:0]           idx, idx_d;
  scan_state_t             state, state_d;
  logic                    slot_end, frame_end;
  logic [4*NUM_DIGITS-1:0] disp, shadow, disp_eff;
  logic [NUM_DIGITS-1:0]   disp_dp, shadow_dp, dp_eff;
  logic                    pending;
  logic                    lz_q, lz_eff, lz_run;
  logic [NUM_DIGITS-1:0]   suppress;
  logic [3:0]              digit;
  seven_seg_t              digit_seg;
  logic [NUM_DIGITS-1:0]   an_d;
  seven_seg_t              seg_d;
  logic                    dp_d;

  always_comb begin
    slot_end  = (cnt == CNT_LAST);
    frame_end = slot_end && (idx == IDX_LAST);
    cnt_d     = slot_end ? '0 : cnt + CW'(1);
    idx_d     = idx;
    if (slot_end) begin
      idx_d = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end
  end

  // The frame_done cycle is also the first cycle of the new frame, so the value
  // about to be committed is used here already and the whole frame stays consistent.
  always_comb begin
    disp_eff = disp;
    dp_eff   = disp_dp;
    if (frame_done && load) begin
      disp_eff = value;
      dp_eff   = dp_in;
    end else if (frame_done && pending) begin
      disp_eff = shadow;
      dp_eff   = shadow_dp;
    end
    lz_eff = (cnt == '0) ? blank_lz : lz_q;
    digit  = disp_eff[{idx, 2'b00} +: 4];
  end

  always_comb begin
    lz_run   = lz_eff;
    suppress = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lz_run      = lz_run && (disp_eff[4*i +: 4] == 4'h0);
      suppress[i] = lz_run;
    end
  end

  seven_seg u_dec (
    .hex (digit),
    .seg (digit_seg)
  );

  always_comb begin
    state_d = (cnt_d < BLANK_END) ? SCAN_BLANK : SCAN_SHOW;
    an_d    = '0;
    seg_d   = '0;
    dp_d    = 1'b0;
    if ((state == SCAN_SHOW) && !suppress[idx]) begin
      an_d  = NUM_DIGITS'(1) << idx;
      seg_d = digit_seg;
      dp_d  = dp_eff[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      state      <= START_STATE;
      disp       <= '0;
      disp_dp    <= '0;
      shadow     <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
      lz_q       <= 1'b0;
      an         <= '0;
      seg        <= '0;
      dp         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_d;
      idx        <= idx_d;
      state      <= state_d;
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
      frame_done <= frame_end;
      if (cnt == '0) begin
        lz_q <= blank_lz;
      end
      if (frame_done) begin
        disp    <= disp_eff;
        disp_dp <= dp_eff;
      end
      if (load && !frame_done) begin
        shadow    <= value;
        shadow_dp <= dp_in;
        pending   <= 1'b1;
      end else if (frame_done) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - scoreboard bench: stimulus queues per-slot expectations,
// a negedge monitor reassembles each output slot and compares
module tb_seven_seg_scan;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  seven_seg_scan #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  slot_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic push_frame(input logic [27:0] segs, input logic [3:0] ens, input logic [3:0] dps);
    slot_t e;
    for (int j = 0; j < 4; j++) begin
      e.an  = ens[j] ? (4'b0001 << j) : 4'b0000;
      e.seg = segs[7*j +: 7];
      e.dp  = dps[j];
      sb.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // Monitor: output slot s covers cycles 8s+1 .. 8s+8 after reset release
  int    k = 0;
  int    pos;
  int    slot;
  logic  rst_prev = 1'b0;
  logic  blank_zero;
  logic  steady;
  slot_t first_show;
  slot_t exp_slot;
  logic [7:0] fd_bits;

  always @(negedge clk) begin
    if (rst) begin
      if (rst_prev) begin
        check_eq("reset_outputs", 32'({an, seg, dp, frame_done}), 32'h0);
      end
      sb.delete();
      k        = 0;
      rst_prev = 1'b1;
    end else begin
      rst_prev = 1'b0;
      if (k == 0) begin
        check_eq("cycle0_outputs", 32'({an, seg, dp, frame_done}), 32'h0);
      end else begin
        pos  = (k - 1) % 8;
        slot = (k - 1) / 8;
        if (pos == 0) begin
          blank_zero = 1'b1;
          steady     = 1'b1;
          fd_bits    = 8'h00;
        end
        fd_bits[pos[2:0]] = frame_done;
        if (pos < 2) begin
          if ({an, seg, dp} != 12'h0) blank_zero = 1'b0;
        end else if (pos == 2) begin
          first_show = {an, seg, dp};
        end else if ({an, seg, dp} != first_show) begin
          steady = 1'b0;
        end
        if (pos == 7) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty slot%0d got no expectation want one queued", slot);
          end else begin
            exp_slot = sb.pop_front();
            check_eq($sformatf("slot%0d_deadtime_zero", slot), 32'(blank_zero), 32'h1);
            check_eq($sformatf("slot%0d_steady", slot), 32'(steady), 32'h1);
            check_eq($sformatf("slot%0d_an_seg_dp", slot), 32'(first_show), 32'(exp_slot));
            check_eq($sformatf("slot%0d_frame_done", slot), 32'(fd_bits),
                     (slot % 4 == 3) ? 32'h80 : 32'h0);
          end
        end
      end
      k++;
    end
  end

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    value    = 16'h0;
    dp_in    = 4'h0;
    blank_lz = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    cyc = 0;

    push_frame({7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b1111, 4'b0000);

    wait_until(2);
    load = 1'b1; value = 16'h1234; dp_in = 4'b0100;
    tick();
    load = 1'b0;

    wait_until(32);
    push_frame({7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b1111, 4'b0100);

    wait_until(42);
    load = 1'b1; value = 16'hABCD; dp_in = 4'b0000;
    tick();
    load = 1'b0;

    wait_until(64);
    push_frame({7'h77, 7'h7C, 7'h39, 7'h5E}, 4'b1111, 4'b0000);

    wait_until(70);
    blank_lz = 1'b1;
    load = 1'b1; value = 16'h0050; dp_in = 4'b0000;
    tick();
    load = 1'b0;

    wait_until(96);
    push_frame({7'h00, 7'h00, 7'h6D, 7'h3F}, 4'b0011, 4'b0000);

    wait_until(100);
    load = 1'b1; value = 16'h0000; dp_in = 4'b0000;
    tick();
    load = 1'b0;

    wait_until(128);
    push_frame({7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0001, 4'b0000);

    // cycle 160 carries frame_done: this load bypasses, the next one waits a frame
    wait_until(160);
    push_frame({7'h6D, 7'h7D, 7'h07, 7'h7F}, 4'b1111, 4'b0001);
    load = 1'b1; value = 16'h5678; dp_in = 4'b0001;
    tick();
    value = 16'h9EF0; dp_in = 4'b0000;
    tick();
    load = 1'b0;

    wait_until(192);
    push_frame({7'h6F, 7'h79, 7'h71, 7'h3F}, 4'b1111, 4'b0000);

    wait_until(211);
    rst      = 1'b1;
    blank_lz = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
    push_frame({7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b1111, 4'b0000);

    wait_until(33);
    check_eq("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
